dll_lock_ctrl: RTL and testbench
================================

# dll_lock_ctrl

Lock sequencer for the fast-lock DLL phase/time control path. It runs the 10-bit successive-approximation delay search against the phase detector's comparison output and issues the phase-detector reset pulse before every trial. Once the search finishes it tracks the loop with ±1 code steps and restarts a full search on loss of lock or a harmonic-lock error. It sits between the phase detector and harmonic lock detector and the delay-line code and coarse decoder.

## Interface
Parameters:
- CODE_W, 10, delay code width
- SETTLE_CYC, 8, cycles waited after each PD reset before sampling comp; legal range 3..255
- UNLOCK_CNT, 16, consecutive same-direction tracking steps that declare loss of lock; legal range 2..255

Ports:
- clk_ext  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level, sampled each edge; starts or restarts a search
- comp  in  1  phase detector output; 1 means delay is too long. Asynchronous; synchronized internally by 2 flops into comp_s
- harm_err  in  1  harmonic-lock error from the detector, synchronous
- code  out  CODE_W  delay-line control code
- reset_pd  out  1  one-cycle phase detector reset, asserted per trial
- busy  out  1  high in every state except IDLE
- locked  out  1  search complete and no loss of lock since
- search_done  out  1  one-cycle pulse when the search completes
- restart_cnt  out  4  number of forced restarts, saturating at 15

## Operation
- States: IDLE, PD_RST, SETTLE, SAMPLE, TRACK_RST, TRACK_SET, TRACK_SMP, and HOLD when tracking is compiled out.
- IDLE: start=1 → code=1<<(CODE_W-1), bit index i=CODE_W-1, go to PD_RST.
- PD_RST: reset_pd=1 for exactly 1 cycle, then SETTLE.
- SETTLE: wait SETTLE_CYC cycles, then SAMPLE.
- SAMPLE (1 cycle):
  - comp_s=1 → clear code[i]; otherwise keep it.
  - If i>0: set code[i-1], decrement i, go to PD_RST.
  - If i=0: search_done=1 and locked=1 on the next cycle, go to TRACK_RST (or HOLD).
- Tracking loop: TRACK_RST (reset_pd 1 cycle) → TRACK_SET (SETTLE_CYC cycles) → TRACK_SMP.
  - TRACK_SMP: comp_s=1 → code-1, saturating at 0; comp_s=0 → code+1, saturating at 2^CODE_W-1.
  - Run counter increments on a step in the same direction as the previous step, including a saturated step. It resets to 1 on a direction change.
  - When the run reaches UNLOCK_CNT: locked=0, restart_cnt++, restart the search from the MSB.
- harm_err=1 at any edge outside IDLE: locked=0, restart_cnt++, restart the search from the MSB in PD_RST. harm_err has priority over a SAMPLE or TRACK_SMP decision on the same edge.
- start=1 during a search: ignored. start=1 in TRACK_*/HOLD: restart the search; restart_cnt does not change and locked=0.
- Reset mid-operation: all state, counters and outputs return to reset values on that edge.

## Timing
- Reset values: code=0, reset_pd=0, busy=0, locked=0, search_done=0, restart_cnt=0, state IDLE, comp synchronizer cleared.
- Per trial: 1 + SETTLE_CYC + 1 cycles (10 with default parameters).
- Search latency: the start edge plus CODE_W·(SETTLE_CYC+2) cycles until search_done; 100 cycles with defaults.
- Tracking: one step every SETTLE_CYC+2 cycles.
- code changes only on SAMPLE/TRACK_SMP edges and on search entry; it is stable during SETTLE.
- comp_s lags comp by 2 cycles, which is why SETTLE_CYC must be at least 3.

## Configuration
- DLL_TRACK_EN defined: the tracking states and run counter are built.
- DLL_TRACK_EN undefined: after the search the block enters HOLD.
  - code is frozen, locked=1, reset_pd=0.
  - harm_err and start still restart the search.
  - The UNLOCK_CNT logic is absent.

## Structure
- Package dll_ctrl_pkg holds:
  - the state enum
  - the default CODE_W, SETTLE_CYC and UNLOCK_CNT values
  - restart_cnt width and saturation constant.
- Sub-module dll_settle_timer: a loadable down-counter with a done flag, shared by SETTLE and TRACK_SET.

## Test plan
- Reset: assert rst mid-search → all outputs 0 on the next edge; busy=0.
- Search: comp model = (code>357) applied with 2-cycle delay; start pulse → code=357, search_done pulse 100 cycles after start; locked=1; reset_pd pulsed 10 times.
- Tracking (DLL_TRACK_EN): after lock, target moves to 360 → code goes 358, 359, 360 and then dithers 360/361; locked stays 1.
- Unlock: locked at 360, target drops to 0 → after 16 consecutive decrements locked=0, restart_cnt=1, new search converges to code=0.
- harm_err: pulse during the bit-5 SAMPLE → decision ignored, code=512 on the next cycle, restart_cnt increments, busy stays 1.
- Boundary: comp held at 1 → search gives code=0; tracking saturates at 0 and restarts every 16 steps; restart_cnt saturates at 15. With DLL_TRACK_EN undefined, code stays at 0 and locked=1.

Source files
------------

// File: rtl/dll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dll_ctrl_pkg
// Description : Shared types and constants for the DLL lock sequencer.
//               Holds the sequencer state encoding, the default delay-code
//               width, settle time and unlock run length, the restart-counter
//               width and saturation value, and a saturating-increment helper
//               for the restart counter.
// Revision    : 1.0 - initial release
// ============================================================================
package dll_ctrl_pkg;

    localparam int c_CODE_W_DEF     = 10;
    localparam int c_SETTLE_CYC_DEF = 8;
    localparam int c_UNLOCK_CNT_DEF = 16;

    // Width of the settle timer and of the tracking run counter
    localparam int c_TIMER_W        = 8;

    localparam int                     c_RESTART_W   = 4;
    localparam logic [c_RESTART_W-1:0] c_RESTART_MAX = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PD_RST    = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_SAMPLE    = 3'd3,
        ST_TRACK_RST = 3'd4,
        ST_TRACK_SET = 3'd5,
        ST_TRACK_SMP = 3'd6,
        ST_HOLD      = 3'd7
    } dll_state_t;

    function automatic logic [c_RESTART_W-1:0] restart_inc(input logic [c_RESTART_W-1:0] cnt);
        restart_inc = (cnt == c_RESTART_MAX) ? cnt : cnt + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dll_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : dll_settle_timer
// Description : Loadable down-counter with a done flag. Loaded with N-1 on
//               the edge that enters a settle state, it reports done during
//               the N-th cycle of that state. Counts down on its own and
//               parks at zero.
// Ports       : clk        - clock
//               rst        - synchronous active-high reset
//               i_load     - load i_load_val on this edge
//               i_load_val - value to load
//               o_done     - counter is at zero
// Revision    : 1.0 - initial release
// ============================================================================
module dll_settle_timer
    import dll_ctrl_pkg::*;
#(
    parameter int CNT_W = c_TIMER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/dll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dll_lock_ctrl
// Description : Lock sequencer for the fast-lock DLL. Runs a successive-
//               approximation search of the delay code against the phase
//               detector output, pulsing the PD reset before every trial.
//               After the search it either tracks with +/-1 steps (restarting
//               on a long same-direction run) or holds the code.
//               Compile-time option: define DLL_TRACK_EN to build the
//               tracking loop; otherwise the block holds after the search.
// Ports       : clk_ext     - clock
//               rst         - synchronous active-high reset
//               start       - start / restart request (level)
//               comp        - PD output, 1 = delay too long (asynchronous)
//               harm_err    - harmonic-lock error (synchronous)
//               code        - delay-line control code
//               reset_pd    - one-cycle PD reset per trial
//               busy        - not idle
//               locked      - search complete, no loss of lock since
//               search_done - one-cycle pulse at search completion
//               restart_cnt - forced restarts, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module dll_lock_ctrl
    import dll_ctrl_pkg::*;
#(
    parameter int CODE_W     = c_CODE_W_DEF,
    parameter int SETTLE_CYC = c_SETTLE_CYC_DEF,
    parameter int UNLOCK_CNT = c_UNLOCK_CNT_DEF
) (
    input  logic                   clk_ext,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   comp,
    input  logic                   harm_err,
    output logic [CODE_W-1:0]      code,
    output logic                   reset_pd,
    output logic                   busy,
    output logic                   locked,
    output logic                   search_done,
    output logic [c_RESTART_W-1:0] restart_cnt
);

    localparam int                   c_BIT_W       = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [CODE_W-1:0]    c_CODE_MSB    = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W-1:0]    c_CODE_ONE    = {{(CODE_W-1){1'b0}}, 1'b1};
    localparam logic [c_BIT_W-1:0]   c_BIT_TOP     = c_BIT_W'(CODE_W - 1);
    localparam logic [c_TIMER_W-1:0] c_SETTLE_LOAD = c_TIMER_W'(SETTLE_CYC - 1);

    // Elaboration guards on parameter ranges
    generate
        if (SETTLE_CYC < 3 || SETTLE_CYC > 255) begin : g_bad_settle
            $error("dll_lock_ctrl: SETTLE_CYC must be in 3..255");
        end
        if (UNLOCK_CNT < 2 || UNLOCK_CNT > 255) begin : g_bad_unlock
            $error("dll_lock_ctrl: UNLOCK_CNT must be in 2..255");
        end
    endgenerate

    dll_state_t             r_state;
    logic [CODE_W-1:0]      r_code;
    logic [c_BIT_W-1:0]     r_bit;
    logic                   r_reset_pd;
    logic                   r_busy;
    logic                   r_locked;
    logic                   r_search_done;
    logic [c_RESTART_W-1:0] r_restart_cnt;
    logic                   r_comp_m;
    logic                   r_comp_s;

    // Two-flop synchronizer for the asynchronous PD output
    always_ff @(posedge clk_ext) begin
        if (rst) begin
            r_comp_m <= 1'b0;
            r_comp_s <= 1'b0;
        end else begin
            r_comp_m <= comp;
            r_comp_s <= r_comp_m;
        end
    end

    logic w_timer_load;
    logic w_timer_done;

    assign w_timer_load = (r_state == ST_PD_RST) || (r_state == ST_TRACK_RST);

    dll_settle_timer #(
        .CNT_W (c_TIMER_W)
    ) u_settle_timer (
        .clk        (clk_ext),
        .rst        (rst),
        .i_load     (w_timer_load),
        .i_load_val (c_SETTLE_LOAD),
        .o_done     (w_timer_done)
    );

    // SAR trial arithmetic: w_trial_code is the code after deciding bit r_bit,
    // w_next_trial additionally sets the next lower bit for the next trial.
    logic [CODE_W-1:0] w_bit_mask;
    logic [CODE_W-1:0] w_trial_code;
    logic [CODE_W-1:0] w_next_trial;

    assign w_bit_mask   = c_CODE_ONE << r_bit;
    assign w_trial_code = r_comp_s ? (r_code & ~w_bit_mask) : r_code;
    assign w_next_trial = w_trial_code | (w_bit_mask >> 1);

`ifdef DLL_TRACK_EN
    localparam logic [CODE_W-1:0] c_CODE_MAX = {CODE_W{1'b1}};

    logic [c_TIMER_W-1:0] r_run;
    logic                 r_dir_up;
    logic                 w_step_up;
    logic [CODE_W-1:0]    w_step_code;
    logic [c_TIMER_W-1:0] w_run_next;
    logic                 w_unlock;

    assign w_step_up   = ~r_comp_s;
    assign w_step_code = w_step_up ? ((r_code == c_CODE_MAX) ? r_code : r_code + c_CODE_ONE)
                                   : ((r_code == '0)         ? r_code : r_code - c_CODE_ONE);
    // r_run == 0 marks "no previous step" right after a search; a saturated
    // step still counts as a step in its direction.
    assign w_run_next  = ((r_run != '0) && (r_dir_up == w_step_up)) ? r_run + c_TIMER_W'(1)
                                                                   : c_TIMER_W'(1);
    assign w_unlock    = (w_run_next == c_TIMER_W'(UNLOCK_CNT));
`endif

    // Restart arbitration: harm_err beats any same-edge decision and is
    // counted; start only restarts from idle or the post-search states.
    logic w_restart;
    logic w_count_restart;
    logic w_post_search;

    assign w_post_search = (r_state == ST_TRACK_RST) || (r_state == ST_TRACK_SET) ||
                           (r_state == ST_TRACK_SMP) || (r_state == ST_HOLD);

    always_comb begin
        w_restart       = 1'b0;
        w_count_restart = 1'b0;
        if ((r_state != ST_IDLE) && harm_err) begin
            w_restart       = 1'b1;
            w_count_restart = 1'b1;
        end else if (((r_state == ST_IDLE) || w_post_search) && start) begin
            w_restart       = 1'b1;
`ifdef DLL_TRACK_EN
        end else if ((r_state == ST_TRACK_SMP) && w_unlock) begin
            w_restart       = 1'b1;
            w_count_restart = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_ext) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_code        <= '0;
            r_bit         <= '0;
            r_reset_pd    <= 1'b0;
            r_busy        <= 1'b0;
            r_locked      <= 1'b0;
            r_search_done <= 1'b0;
            r_restart_cnt <= '0;
`ifdef DLL_TRACK_EN
            r_run         <= '0;
            r_dir_up      <= 1'b0;
`endif
        end else begin
            r_reset_pd    <= 1'b0;
            r_search_done <= 1'b0;
            if (w_restart) begin
                r_state    <= ST_PD_RST;
                r_code     <= c_CODE_MSB;
                r_bit      <= c_BIT_TOP;
                r_reset_pd <= 1'b1;
                r_busy     <= 1'b1;
                r_locked   <= 1'b0;
                if (w_count_restart) begin
                    r_restart_cnt <= restart_inc(r_restart_cnt);
                end
            end else begin
                case (r_state)
                    ST_PD_RST: begin
                        r_state <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (w_timer_done) begin
                            r_state <= ST_SAMPLE;
                        end
                    end
                    ST_SAMPLE: begin
                        if (r_bit != '0) begin
                            r_code     <= w_next_trial;
                            r_bit      <= r_bit - c_BIT_W'(1);
                            r_state    <= ST_PD_RST;
                            r_reset_pd <= 1'b1;
                        end else begin
                            r_code        <= w_trial_code;
                            r_search_done <= 1'b1;
                            r_locked      <= 1'b1;
`ifdef DLL_TRACK_EN
                            r_state       <= ST_TRACK_RST;
                            r_reset_pd    <= 1'b1;
                            r_run         <= '0;
`else
                            r_state       <= ST_HOLD;
`endif
                        end
                    end
`ifdef DLL_TRACK_EN
                    ST_TRACK_RST: begin
                        r_state <= ST_TRACK_SET;
                    end
                    ST_TRACK_SET: begin
                        if (w_timer_done) begin
                            r_state <= ST_TRACK_SMP;
                        end
                    end
                    ST_TRACK_SMP: begin
                        r_code     <= w_step_code;
                        r_run      <= w_run_next;
                        r_dir_up   <= w_step_up;
                        r_state    <= ST_TRACK_RST;
                        r_reset_pd <= 1'b1;
                    end
`endif
                    ST_IDLE, ST_HOLD: begin
                        r_state <= r_state;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign code        = r_code;
    assign reset_pd    = r_reset_pd;
    assign busy        = r_busy;
    assign locked      = r_locked;
    assign search_done = r_search_done;
    assign restart_cnt = r_restart_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dll_lock_ctrl
// Description : Directed self-checking bench for dll_lock_ctrl with default
//               parameters. Phase detector model: comp = (code > target),
//               or forced high. Tracking checks are built when DLL_TRACK_EN
//               is defined, hold checks otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dll_lock_ctrl;

    localparam int CODE_W = 10;

    logic              clk_ext  = 1'b0;
    logic              rst      = 1'b1;
    logic              start    = 1'b0;
    logic              comp     = 1'b0;
    logic              harm_err = 1'b0;
    logic [CODE_W-1:0] code;
    logic              reset_pd;
    logic              busy;
    logic              locked;
    logic              search_done;
    logic [3:0]        restart_cnt;

    int   n_checks   = 0;
    int   n_errors   = 0;
    int   pd_cnt     = 0;
    int   target     = 357;
    logic comp_force = 1'b0;
    int   exp_rc     = 0;

    dll_lock_ctrl dut (
        .clk_ext     (clk_ext),
        .rst         (rst),
        .start       (start),
        .comp        (comp),
        .harm_err    (harm_err),
        .code        (code),
        .reset_pd    (reset_pd),
        .busy        (busy),
        .locked      (locked),
        .search_done (search_done),
        .restart_cnt (restart_cnt)
    );

    always #5 clk_ext = ~clk_ext;

    // Phase detector model
    always @(posedge clk_ext) begin
        #1;
        comp = comp_force | (int'(code) > target);
    end

    task automatic tick();
        @(posedge clk_ext);
        #1;
        if (reset_pd === 1'b1) pd_cnt++;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // ---- reset values ----
        rst = 1'b1;
        tick_n(3);
        check("rst_code", code, 0);
        check("rst_reset_pd", reset_pd, 0);
        check("rst_busy", busy, 0);
        check("rst_locked", locked, 0);
        check("rst_search_done", search_done, 0);
        check("rst_restart_cnt", restart_cnt, 0);

        // ---- full search to 357 ----
        rst    = 1'b0;
        target = 357;
        start  = 1'b1;
        pd_cnt = 0;
        tick();                                  // E0
        start = 1'b0;
        check("srch_entry_code", code, 512);
        check("srch_entry_busy", busy, 1);
        check("srch_entry_pd", reset_pd, 1);
        tick_n(99);                              // E99
        check("srch_done_early", search_done, 0);
        check("srch_pd_pulses", pd_cnt, 10);
        tick();                                  // E100
        check("srch_done", search_done, 1);
        check("srch_code", code, 357);
        check("srch_locked", locked, 1);
        tick();                                  // E101
        check("srch_done_pulse", search_done, 0);

`ifdef DLL_TRACK_EN
        // ---- tracking toward 360, then dither ----
        target = 360;
        tick_n(9);                               // E110
        check("trk_step1", code, 358);
        tick_n(10);
        check("trk_step2", code, 359);
        tick_n(10);
        check("trk_step3", code, 360);
        tick_n(10);
        check("trk_dither_up", code, 361);
        tick_n(10);                              // E150
        check("trk_dither_dn", code, 360);
        check("trk_locked", locked, 1);

        // ---- loss of lock: run started by the 361->360 step ----
        target = 0;
        tick_n(140);                             // E290
        check("unl_last_code", code, 346);
        check("unl_still_locked", locked, 1);
        tick_n(10);                              // E300
        check("unl_locked", locked, 0);
        check("unl_restart_cnt", restart_cnt, 1);
        check("unl_code", code, 512);
        exp_rc = 1;
        tick_n(100);                             // E400
        check("unl_resrch_done", search_done, 1);
        check("unl_resrch_code", code, 0);
`else
        // ---- hold: code frozen, no PD resets ----
        target = 0;
        pd_cnt = 0;
        tick_n(50);
        check("hold_code", code, 357);
        check("hold_locked", locked, 1);
        check("hold_pd_pulses", pd_cnt, 0);
`endif

        // ---- start after search: restart, not counted ----
        target = 200;
        start  = 1'b1;
        tick();                                  // S0
        start = 1'b0;
        check("rs_code", code, 512);
        check("rs_locked", locked, 0);
        check("rs_restart_cnt", restart_cnt, exp_rc);
        check("rs_busy", busy, 1);

        // ---- harm_err on the bit-5 SAMPLE edge ----
        tick_n(49);
        harm_err = 1'b1;
        tick();                                  // S50
        harm_err = 1'b0;
        check("harm_code", code, 512);
        check("harm_restart_cnt", restart_cnt, exp_rc + 1);
        check("harm_busy", busy, 1);
        check("harm_pd", reset_pd, 1);
        exp_rc = exp_rc + 1;

        // ---- start during search is ignored ----
        tick_n(25);
        start = 1'b1;
        tick();                                  // S'26
        start = 1'b0;
        check("ign_start_code", code, 128);
        tick_n(73);                              // S'99
        check("ign_done_early", search_done, 0);
        tick();                                  // S'100
        check("ign_done", search_done, 1);
        check("ign_code", code, 200);
        check("ign_restart_cnt", restart_cnt, exp_rc);

        // ---- comp stuck high: search bottoms out at 0 ----
        comp_force = 1'b1;
        start      = 1'b1;
        tick();                                  // B0
        start = 1'b0;
        tick_n(99);                              // B99
        check("bnd_last_trial", code, 1);
        tick();                                  // B100
        check("bnd_code", code, 0);
        check("bnd_done", search_done, 1);
        check("bnd_locked", locked, 1);
`ifdef DLL_TRACK_EN
        tick_n(159);                             // B259
        check("bnd_sat_code", code, 0);
        check("bnd_sat_locked", locked, 1);
        tick();                                  // B260
        check("bnd_unl_locked", locked, 0);
        check("bnd_unl_code", code, 512);
        check("bnd_unl_restart_cnt", restart_cnt, exp_rc + 1);
`else
        pd_cnt = 0;
        tick_n(40);
        check("bnd_hold_code", code, 0);
        check("bnd_hold_locked", locked, 1);
        check("bnd_hold_pd", pd_cnt, 0);
`endif

        // ---- restart counter saturation ----
        harm_err = 1'b1;
        tick_n(20);
        harm_err = 1'b0;
        check("sat_restart_cnt", restart_cnt, 15);
        check("sat_busy", busy, 1);
        check("sat_code", code, 512);

        // ---- reset mid-search ----
        tick_n(5);
        rst = 1'b1;
        tick();
        check("mrst_code", code, 0);
        check("mrst_busy", busy, 0);
        check("mrst_restart_cnt", restart_cnt, 0);
        check("mrst_reset_pd", reset_pd, 0);
        check("mrst_locked", locked, 0);
        rst = 1'b0;

        // ---- harm_err ignored in idle ----
        harm_err = 1'b1;
        tick_n(3);
        harm_err = 1'b0;
        check("idle_harm_busy", busy, 0);
        check("idle_harm_restart_cnt", restart_cnt, 0);
        check("idle_harm_code", code, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
